// File: rtl/i2s_pkg.sv
// Shared frame geometry and lrclk polarity for the 64x I2S transmitter.
package i2s_pkg;

  localparam int SLOT_BITS   = 32;
  localparam int FRAME_BITS  = 64;
  localparam int FRAME_POS_W = 6;

  localparam logic LRCLK_LEFT = 1'b1;

  // Positions 0..31 are the left slot, 32..63 the right slot.
  function automatic logic lrclk_for_pos(input logic [FRAME_POS_W-1:0] pos);
    return (pos[FRAME_POS_W-1] == 1'b0) ? LRCLK_LEFT : ~LRCLK_LEFT;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_HALF clks and flags the clk edge of each rise/fall.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BCLK_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  always_comb begin
    wrap      = (cnt_q == CNT_MAX);
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    bclk_d    = wrap ? ~bclk_q : bclk_q;
    rise_tick = wrap && !bclk_q;
    fall_tick = wrap && bclk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;

endmodule

// File: rtl/i2s_tx_64x.sv
// Master I2S transmitter, 64 bclk frame (32-bit left then right slot), MSB first, one-bclk delay.
// Build option I2S_TX_MUTE_ON_UNDERRUN_EN: an underrun frame sends silence instead of repeating.
module i2s_tx_64x
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BCLK_HALF  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic [DATA_WIDTH-1:0] right_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdout,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int SW = FRAME_POS_W - 1;
  localparam logic [SW-1:0] LAST_DATA_SLOT = SW'(DATA_WIDTH);

  logic rise_tick_unused;
  logic fall_tick;

  i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
    .clk       (clk),
    .rst       (rst),
    .bclk      (bclk),
    .rise_tick (rise_tick_unused),
    .fall_tick (fall_tick)
  );

  logic [DATA_WIDTH-1:0]  hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]  sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [FRAME_POS_W-1:0] frame_pos_q, frame_pos_d;
  logic                   lrclk_q, lrclk_d;
  logic                   sdout_q, sdout_d;
  logic                   frame_start_q, frame_start_d;
  logic                   underrun_q, underrun_d;

  logic [FRAME_POS_W-1:0] next_pos;
  logic [SW-1:0]          slot;
  logic                   accept;

  // Handshake: valid/ready, a pair transfers on any clk where both are high; the source holds data until then.
  always_comb begin
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    hold_full_d   = hold_full_q;
    sh_l_d        = sh_l_q;
    sh_r_d        = sh_r_q;
    frame_pos_d   = frame_pos_q;
    lrclk_d       = lrclk_q;
    sdout_d       = sdout_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    next_pos = frame_pos_q + FRAME_POS_W'(1);
    slot     = next_pos[SW-1:0];
    accept   = sample_valid && !hold_full_q;

    if (fall_tick) begin
      frame_pos_d = next_pos;
      lrclk_d     = lrclk_for_pos(next_pos);
      sdout_d     = 1'b0;
      if (next_pos == '0) begin
        frame_start_d = 1'b1;
        if (hold_full_q) begin
          sh_l_d      = hold_l_q;
          sh_r_d      = hold_r_q;
          hold_full_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          sh_l_d = '0;
          sh_r_d = '0;
`endif
        end
      end else if (slot != '0 && slot <= LAST_DATA_SLOT) begin
        // Rotating rather than shifting keeps the pair intact for an underrun repeat.
        if (lrclk_for_pos(next_pos) == LRCLK_LEFT) begin
          sdout_d = sh_l_q[DATA_WIDTH-1];
          sh_l_d  = {sh_l_q[DATA_WIDTH-2:0], sh_l_q[DATA_WIDTH-1]};
        end else begin
          sdout_d = sh_r_q[DATA_WIDTH-1];
          sh_r_d  = {sh_r_q[DATA_WIDTH-2:0], sh_r_q[DATA_WIDTH-1]};
        end
      end
    end

    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = left_data;
      hold_r_d    = right_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      sh_l_q        <= '0;
      sh_r_q        <= '0;
      frame_pos_q   <= FRAME_POS_W'(FRAME_BITS - 1);
      lrclk_q       <= 1'b0;
      sdout_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      sh_l_q        <= sh_l_d;
      sh_r_q        <= sh_r_d;
      frame_pos_q   <= frame_pos_d;
      lrclk_q       <= lrclk_d;
      sdout_q       <= sdout_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = !hold_full_q;
  assign lrclk        = lrclk_q;
  assign sdout        = sdout_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_64x.sv
// Bench for i2s_tx_64x: random pairs, a receiver-side monitor that rebuilds each frame, and a model scoreboard.
module tb_i2s_tx_64x;

  localparam int DW = 16;
  localparam int BH = 2;
  localparam int EW = 2 * DW + 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] left_data = '0;
  logic [DW-1:0] right_data = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready, bclk, lrclk, sdout, frame_start, underrun;

  i2s_tx_64x #(.DATA_WIDTH(DW), .BCLK_HALF(BH)) dut (
    .clk          (clk),
    .rst          (rst),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdout        (sdout),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Each entry: {left, right, clk edge number at which the pair was accepted}.
  logic [EW-1:0] exp_q[$];

  logic          active = 1'b0;
  int            nbits = 0;
  int            frames = 0;
  logic [63:0]   cap_sd, cap_lr;
  logic [DW-1:0] cur_l = '0, cur_r = '0, last_l = '0, last_r = '0;
  logic          bclk_prev = 1'b0;
  logic          exp_und;
  logic [EW-1:0] ent;

  // A slot on the wire: one delay bit, the sample MSB first, zero padding.
  function automatic logic [31:0] slot_of(input logic [DW-1:0] s);
    logic [31:0] v;
    v = '0;
    v[30 -: DW] = s;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      active = 1'b0;
      nbits  = 0;
      last_l = '0;
      last_r = '0;
    end else begin
      if (bclk && !bclk_prev && active) begin
        cap_sd = {cap_sd[62:0], sdout};
        cap_lr = {cap_lr[62:0], lrclk};
        nbits++;
      end
      if (underrun && !frame_start) check("underrun_without_frame_start", 1, 0);
      if (frame_start) begin
        if (active) begin
          check("frame_len_bits", 64'(nbits), 64);
          check("frame_sdout", cap_sd, {slot_of(cur_l), slot_of(cur_r)});
          check("frame_lrclk", cap_lr, {32'hFFFF_FFFF, 32'h0});
        end
        // Only pairs accepted strictly before this load edge make it into the frame.
        if (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
          ent     = exp_q.pop_front();
          cur_l   = ent[EW-1 -: DW];
          cur_r   = ent[DW+31 -: DW];
          exp_und = 1'b0;
        end else begin
          exp_und = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          cur_l = '0;
          cur_r = '0;
`else
          cur_l = last_l;
          cur_r = last_r;
`endif
        end
        last_l = cur_l;
        last_r = cur_r;
        check("underrun_flag", 64'(underrun), 64'(exp_und));
        active = 1'b1;
        nbits  = 0;
        cap_sd = '0;
        cap_lr = '0;
        frames++;
      end
    end
    bclk_prev = bclk;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int t = 0;
    @(negedge clk);
    sample_valid = 1'b1;
    left_data    = l;
    right_data   = r;
    while (!sample_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!sample_ready) begin
      check("send_timeout", 1, 0);
      sample_valid = 1'b0;
      return;
    end
    exp_q.push_back({l, r, 32'(cyc + 1)});
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int start = frames;
    int t = 0;
    while (frames < start + n && t < 400 * n) begin
      @(negedge clk);
      t++;
    end
    if (frames < start + n) check("wait_frames_timeout", 64'(frames), 64'(start + n));
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    while (!(active && nbits == n) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!(active && nbits == n)) check("wait_bits_timeout", 64'(nbits), 64'(n));
  endtask

  task automatic wait_queue_empty();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", 64'(exp_q.size()), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bclk"}, 64'(bclk), 0);
    check({tag, "_lrclk"}, 64'(lrclk), 0);
    check({tag, "_sdout"}, 64'(sdout), 0);
    check({tag, "_frame_start"}, 64'(frame_start), 0);
    check({tag, "_underrun"}, 64'(underrun), 0);
    check({tag, "_ready"}, 64'(sample_ready), 1);
  endtask

  // Releases reset and checks the first bclk rise/fall timing and the first frame load.
  task automatic release_and_check();
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("rel_clk1_bclk", 64'(bclk), 0);
    @(posedge clk) #1;
    check("rel_clk2_bclk_rise", 64'(bclk), 1);
    check("rel_clk2_lrclk", 64'(lrclk), 0);
    @(posedge clk) #1;
    check("rel_clk3_bclk", 64'(bclk), 1);
    @(posedge clk) #1;
    check("rel_clk4_bclk_fall", 64'(bclk), 0);
    check("rel_clk4_lrclk", 64'(lrclk), 1);
    check("rel_clk4_frame_start", 64'(frame_start), 1);
    check("rel_clk4_underrun", 64'(underrun), 1);
    check("rel_clk4_ready", 64'(sample_ready), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] l2, r2;
    int t;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    release_and_check();

    // Directed pair, then a frame with no new data (underrun repeat).
    send(16'hA5C3, 16'h0F0F);
    wait_frames(3);

    // Backpressure: second pair offered while the holding register is full.
    send(DW'($urandom), DW'($urandom));
    l2 = DW'($urandom);
    r2 = DW'($urandom);
    @(negedge clk);
    sample_valid = 1'b1;
    left_data    = l2;
    right_data   = r2;
    check("bp_ready_low", 64'(sample_ready), 0);
    t = 0;
    while (!sample_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("bp_accept_with_frame_start", 64'(frame_start), 1);
    exp_q.push_back({l2, r2, 32'(cyc + 1)});
    @(posedge clk);
    #1 sample_valid = 1'b0;
    wait_frames(3);

    // Random pairs with random gaps, including gaps that land on load edges.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 400)) @(negedge clk);
      send(DW'($urandom), DW'($urandom));
    end
    wait_queue_empty();
    wait_frames(2);

    // Mid-frame reset at frame_pos 40 with a pair still pending in the holding register.
    wait_bits(20);
    send(DW'($urandom), DW'($urandom));
    wait_bits(41);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    release_and_check();

    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 300)) @(negedge clk);
      send(DW'($urandom), DW'($urandom));
    end
    wait_queue_empty();
    wait_frames(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
